// File: rtl/core_rf_pkg.sv
// core_rf_pkg: shared constants, types and write-port arbitration for the register file
package core_rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int MAX_WR   = 3;
    localparam int MAX_AW   = 16;

    typedef logic [$clog2(NREG_DEF)-1:0] reg_id_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_pick_t;

    // Highest-index enabled port targeting id wins; unused ports must have en=0.
    function automatic wr_pick_t rf_pick_writer(
        input logic [MAX_WR-1:0]             en,
        input logic [MAX_WR-1:0][MAX_AW-1:0] ids,
        input logic [MAX_AW-1:0]             id
    );
        wr_pick_t pk = '0;
        for (int p = 0; p < MAX_WR; p++)
            if (en[p] && ids[p] == id) begin
                pk.hit  = 1'b1;
                pk.port = 2'(p);
            end
        return pk;
    endfunction

endpackage

// File: rtl/core_rf_scoreboard.sv
// core_rf_scoreboard: per-register busy bits with reservation handshake and clear-on-write
module core_rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREG-1:0] clr_i,
    input  logic            rsv_valid_i,
    input  logic [AW-1:0]   rsv_id_i,
    output logic            rsv_ready_o,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q, busy_d;

    assign rsv_ready_o = rsv_valid_i && (rsv_id_i == '0 || !busy_q[rsv_id_i]);
    assign busy_o      = busy_q;

    // Writes release their targets; an accepted reservation sets after the clear so it wins.
    always_comb begin
        busy_d = busy_q & ~clr_i;
        if (rsv_ready_o)
            busy_d[rsv_id_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;

endmodule

// File: rtl/core_reg_file_sb.sv
// core_reg_file_sb: multi-port integer register file with scoreboard.
// Define CORE_REG_FILE_SB_BYPASS_EN to forward same-cycle writes to the read ports.
module core_reg_file_sb
    import core_rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_id,
    output logic [NRD*XLEN-1:0] rd_value,
    output logic [NRD-1:0]      rd_busy,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_id,
    output logic                rsv_ready,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_id,
    input  logic [NWR*XLEN-1:0] wr_value
);

    logic [NRD-1:0][AW-1:0]       rid;
    logic [NRD-1:0][XLEN-1:0]     rval;
    logic [NWR-1:0][AW-1:0]       wid;
    logic [NWR-1:0][XLEN-1:0]     wval;
    logic [MAX_WR-1:0]            en_pad;
    logic [MAX_WR-1:0][MAX_AW-1:0] ids_pad;
    logic [MAX_WR-1:0][XLEN-1:0]  val_pad;
    logic [XLEN-1:0]              regs_q [NREG];
    logic [XLEN-1:0]              regs_d [NREG];
    logic [NREG-1:0]              clr;
    logic [NREG-1:0]              busy;
    wr_pick_t                     wpk;

    assign rid      = rd_id;
    assign wid      = wr_id;
    assign wval     = wr_value;
    assign rd_value = rval;

    // Widen the write ports to the arbiter's fixed width; absent ports never hit.
    always_comb begin
        en_pad  = '0;
        ids_pad = '0;
        val_pad = '0;
        for (int p = 0; p < NWR; p++) begin
            en_pad[p]  = wr_en[p];
            ids_pad[p] = MAX_AW'(wid[p]);
            val_pad[p] = wval[p];
        end
    end

    // Per-register write arbitration; r0 is never written or released.
    always_comb begin
        regs_d = regs_q;
        clr    = '0;
        wpk    = '0;
        for (int r = 1; r < NREG; r++) begin
            wpk = rf_pick_writer(en_pad, ids_pad, MAX_AW'(r));
            if (wpk.hit) begin
                regs_d[r] = val_pad[wpk.port];
                clr[r]    = 1'b1;
            end
        end
    end

    // Data storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;

    core_rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .rsv_valid_i (rsv_valid),
        .rsv_id_i    (rsv_id),
        .rsv_ready_o (rsv_ready),
        .busy_o      (busy)
    );

`ifdef CORE_REG_FILE_SB_BYPASS_EN
    wr_pick_t rpk;

    // Read mux with same-cycle forwarding; a forwarded read is busy only if re-reserved now.
    always_comb begin
        rval    = '0;
        rd_busy = '0;
        rpk     = '0;
        for (int i = 0; i < NRD; i++) begin
            rval[i]    = regs_q[rid[i]];
            rd_busy[i] = busy[rid[i]];
            rpk        = rf_pick_writer(en_pad, ids_pad, MAX_AW'(rid[i]));
            if (rpk.hit && rid[i] != '0) begin
                rval[i]    = val_pad[rpk.port];
                rd_busy[i] = rsv_ready && rsv_id == rid[i];
            end
        end
    end
`else
    // Read mux from registered state only.
    always_comb begin
        rval    = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rval[i]    = regs_q[rid[i]];
            rd_busy[i] = busy[rid[i]];
        end
    end
`endif

endmodule

// File: tb/tb_core_reg_file_sb.sv
// tb_core_reg_file_sb: directed self-checking bench for core_reg_file_sb
module tb_core_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_id = '0;
    logic [63:0] rd_value;
    logic [1:0]  rd_busy;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_id = '0;
    logic        rsv_ready;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_id = '0;
    logic [63:0] wr_value = '0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    core_reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_id     (rd_id),
        .rd_value  (rd_value),
        .rd_busy   (rd_busy),
        .rsv_valid (rsv_valid),
        .rsv_id    (rsv_id),
        .rsv_ready (rsv_ready),
        .wr_en     (wr_en),
        .wr_id     (wr_id),
        .wr_value  (wr_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = '0;
        rsv_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rsv_valid = 1'b1; rsv_id = 5'd7; rd_id = {5'd7, 5'd5};
        #1;
        total++; if (rd_value !== 64'h0) begin bad++; $display("FAIL init_value got %h want %h", rd_value, 64'h0); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL init_busy got %b want %b", rd_busy, 2'b00); end
        total++; if (rsv_ready !== 1'b1) begin bad++; $display("FAIL init_ready got %b want %b", rsv_ready, 1'b1); end
        tick();
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst_hold_busy got %b want %b", rd_busy, 2'b00); end
        rst_n = 1'b1;
        wr_en = 2'b01; wr_id = {5'd0, 5'd5}; wr_value = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        #1;
        total++; if (rd_value !== {32'h0, 32'hDEADBEEF}) begin bad++; $display("FAIL pre_rst_value got %h want %h", rd_value, {32'h0, 32'hDEADBEEF}); end
        total++; if (rd_busy !== 2'b10) begin bad++; $display("FAIL pre_rst_busy got %b want %b", rd_busy, 2'b10); end
        rst_n = 1'b0;
        rsv_valid = 1'b1; rsv_id = 5'd7;
        #1;
        total++; if (rd_value !== 64'h0) begin bad++; $display("FAIL rst_value got %h want %h", rd_value, 64'h0); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst_busy got %b want %b", rd_busy, 2'b00); end
        total++; if (rsv_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want %b", rsv_ready, 1'b1); end
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst_discard got %b want %b", rd_busy, 2'b00); end
    endtask

    task automatic test_write_conflict();
        wr_en = 2'b11; wr_id = {5'd3, 5'd3}; wr_value = {32'h22, 32'h11};
        tick();
        idle();
        rd_id = {5'd0, 5'd3};
        #1;
        total++; if (rd_value[31:0] !== 32'h22) begin bad++; $display("FAIL conflict got %h want %h", rd_value[31:0], 32'h22); end
        wr_en = 2'b10; wr_id = {5'd0, 5'd4}; wr_value = {32'hFF, 32'h0};
        tick();
        idle();
        #1;
        total++; if (rd_value[63:32] !== 32'h0) begin bad++; $display("FAIL r0_write got %h want %h", rd_value[63:32], 32'h0); end
        rsv_valid = 1'b1; rsv_id = 5'd0;
        #1;
        total++; if (rsv_ready !== 1'b1) begin bad++; $display("FAIL r0_rsv_ready got %b want %b", rsv_ready, 1'b1); end
        tick();
        idle();
        #1;
        total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL r0_busy got %b want %b", rd_busy[1], 1'b0); end
    endtask

    task automatic test_scoreboard();
        rd_id = {5'd3, 5'd9};
        rsv_valid = 1'b1; rsv_id = 5'd9;
        #1;
        total++; if (rsv_ready !== 1'b1) begin bad++; $display("FAIL rsv_first got %b want %b", rsv_ready, 1'b1); end
        tick();
        total++; if (rd_busy !== 2'b01) begin bad++; $display("FAIL rsv_busy got %b want %b", rd_busy, 2'b01); end
        total++; if (rsv_ready !== 1'b0) begin bad++; $display("FAIL rsv_again got %b want %b", rsv_ready, 1'b0); end
        wr_en = 2'b01; wr_id = {5'd0, 5'd9}; wr_value = {32'h0, 32'h55};
        #1;
        total++; if (rsv_ready !== 1'b0) begin bad++; $display("FAIL rsv_release_same got %b want %b", rsv_ready, 1'b0); end
        tick();
        wr_en = '0;
        #1;
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL release_busy got %b want %b", rd_busy, 2'b00); end
        total++; if (rd_value[31:0] !== 32'h55) begin bad++; $display("FAIL release_value got %h want %h", rd_value[31:0], 32'h55); end
        total++; if (rsv_ready !== 1'b1) begin bad++; $display("FAIL rsv_reaccept got %b want %b", rsv_ready, 1'b1); end
        tick();
        idle();
        #1;
        total++; if (rd_busy !== 2'b01) begin bad++; $display("FAIL rsv_rebusy got %b want %b", rd_busy, 2'b01); end
    endtask

    task automatic test_set_over_clear();
        rd_id = {5'd9, 5'd4};
        wr_en = 2'b01; wr_id = {5'd0, 5'd4}; wr_value = {32'h0, 32'h1};
        rsv_valid = 1'b1; rsv_id = 5'd4;
        tick();
        idle();
        #1;
        total++; if (rd_value[31:0] !== 32'h1) begin bad++; $display("FAIL soc_value got %h want %h", rd_value[31:0], 32'h1); end
        total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL soc_busy got %b want %b", rd_busy, 2'b11); end
    endtask

    task automatic test_bypass();
        wr_en = 2'b10; wr_id = {5'd6, 5'd0}; wr_value = {32'h1234, 32'h0};
        rsv_valid = 1'b1; rsv_id = 5'd6;
        tick();
        idle();
        rd_id = {5'd6, 5'd6};
        wr_en = 2'b01; wr_id = {5'd0, 5'd6}; wr_value = {32'h0, 32'hA5A5};
        #1;
`ifdef CORE_REG_FILE_SB_BYPASS_EN
        total++; if (rd_value !== {32'hA5A5, 32'hA5A5}) begin bad++; $display("FAIL byp_value got %h want %h", rd_value, {32'hA5A5, 32'hA5A5}); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL byp_busy got %b want %b", rd_busy, 2'b00); end
`else
        total++; if (rd_value !== {32'h1234, 32'h1234}) begin bad++; $display("FAIL nobyp_value got %h want %h", rd_value, {32'h1234, 32'h1234}); end
        total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL nobyp_busy got %b want %b", rd_busy, 2'b11); end
`endif
        tick();
        idle();
        #1;
        total++; if (rd_value !== {32'hA5A5, 32'hA5A5}) begin bad++; $display("FAIL byp_next_value got %h want %h", rd_value, {32'hA5A5, 32'hA5A5}); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL byp_next_busy got %b want %b", rd_busy, 2'b00); end
    endtask

    task automatic test_back_to_back();
        rd_id = {5'd3, 5'd5};
        wr_en = 2'b11; wr_id = {5'd3, 5'd5}; wr_value = {32'hC0DE, 32'hBEEF};
        tick();
        wr_en = 2'b11; wr_id = {5'd5, 5'd3}; wr_value = {32'h7777, 32'h8888};
        tick();
        idle();
        #1;
        total++; if (rd_value !== {32'h8888, 32'h7777}) begin bad++; $display("FAIL b2b_value got %h want %h", rd_value, {32'h8888, 32'h7777}); end
    endtask

    initial begin
        test_reset();
        test_write_conflict();
        test_scoreboard();
        test_set_over_clear();
        test_bypass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_reg_file_sb.md
# core_reg_file_sb

Parametrised integer register file with built-in scoreboard for the core's EXEC stage. Generalises the single-write, two-read register file to `NRD` read ports and `NWR` write ports, adds an asynchronous clear of all registers, and tracks per-register "busy" bits so multi-cycle producers (loads, mul/div) can reserve a destination at issue and release it at write-back. Optional same-cycle write-to-read bypass.

## Interface

**Parameters**
- `XLEN`, 32: register data width.
- `NREG`, 32: number of registers. Power of two, at least 2. `AW = $clog2(NREG)`.
- `NRD`, 2: number of read ports, 1..4.
- `NWR`, 2: number of write ports, 1..3. A higher index means higher priority.

**Ports**
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rd_id`, in, `NRD*AW`: read register indices, packed with port 0 in the LSBs.
- `rd_value`, out, `NRD*XLEN`: read data.
- `rd_busy`, out, `NRD`: scoreboard busy bit of each read register.
- `rsv_valid`, in, 1: request to reserve `rsv_id`.
- `rsv_id`, in, `AW`: destination to reserve.
- `rsv_ready`, out, 1: reservation accepted this cycle.
- `wr_en`, in, `NWR`: write strobe per port.
- `wr_id`, in, `NWR*AW`: write indices.
- `wr_value`, in, `NWR*XLEN`: write data.

## Operation
- **Storage.** Register 0 reads 0, ignores writes and is never busy.
- **Writes.** On each edge, for every register r ≠ 0, take the highest-index port p with `wr_en[p]` and `wr_id[p]==r`. Write `wr_value[p]` to r and clear `busy[r]`.
- **Reservation.** `rsv_ready = rsv_valid & (rsv_id==0 | !busy[rsv_id])`, combinational from registered busy bits. A same-cycle release does not make `rsv_ready` high.
- **Reservation fire.** When `rsv_valid & rsv_ready` and `rsv_id ≠ 0`, `busy[rsv_id]` is set at the edge. Reserving r0 is accepted as a no-op.
- **Set wins over clear.** A same-cycle write to r and accepted reservation of r leaves r written with the new value and `busy[r]=1`.
- **Writes to non-busy registers** (single-cycle producers) are legal and simply write.
- **Reads.** `rd_value[i]` and `rd_busy[i]` are combinational in `rd_id[i]`. The bypass behaviour is set by the macro described in Configuration.
- **Reset.** While `rst_n` is low, all registers are 0 and all busy bits are 0. Hence `rd_value` is 0, `rd_busy` is 0, and `rsv_ready` equals `rsv_valid`. A pending reservation is discarded.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge; without bypass, the value is visible on the cycle after the strobe.
- Busy set and clear take effect at the edge. `rd_busy` reflects the new state on the next cycle (or the same cycle for clears under bypass).
- The reservation handshake is single-cycle. There is no holding requirement: a dropped `rsv_valid` is simply not recorded.
- Reset assertion is asynchronous and takes effect immediately. Deassertion is sampled normally, and the first write is allowed on the first edge with `rst_n` high.

## Configuration
- **Macro:** `CORE_REG_FILE_SB_BYPASS_EN`.
- **Defined:** if any `wr_en[p]` targets `rd_id[i]` ≠ 0 this cycle, `rd_value[i]` returns the highest-priority such `wr_value[p]`. `rd_busy[i]` then shows 0 unless a reservation of the same id also fires this cycle, in which case it shows 1.
- **Undefined:** reads return only registered state. The pipeline must stall one cycle for a read-after-write.

## Structure
- **Package `core_rf_pkg`:**
  - default `XLEN`/`NREG` constants;
  - `reg_id_t` typedef;
  - function `rf_pick_writer` returning the winning port index and a hit flag for a given id.
- **Sub-module `core_rf_scoreboard`:**
  - holds the `NREG` busy bits;
  - provides the reservation handshake and the clear-on-write logic;
  - takes `clk`/`rst_n`.
- **Top level:** keeps data storage, write arbitration and read/bypass muxing.

## Test plan
- **Reset:** assert `rst_n=0` mid-run after writing r5=0xDEADBEEF and reserving r7. Read r5 and r7 → value 0, busy 0, `rsv_ready=1`.
- **Write conflict:** same cycle, port0 writes r3=0x11 and port1 writes r3=0x22. Next cycle read r3 → 0x22. Write r0=0xFF → reads 0.
- **Scoreboard:** reserve r9, accepted. Reserve r9 again → `rsv_ready=0`. Write r9=0x55 → busy clears next cycle, re-reserve accepted.
- **Set over clear:** write r4=0x1 and reserve r4 in the same cycle. Next cycle → r4=0x1, busy=1.
- **Bypass defined:** write r6=0xA5A5 while reading r6 on all ports in the same cycle → all `rd_value` return 0xA5A5. Busy r6 being cleared → `rd_busy=0`.
- **Bypass undefined:** repeat the previous scenario → old value and old busy in the same cycle, new value next cycle.
